// File: rtl/sevenseg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous shadow
// latching, anti-ghost blanking and optional leading-zero suppression.

module hexdecoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Active-low gfedcba pattern for a common-anode display.
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

module sevenseg_scanner #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic [2:0]            digit_idx,
  output logic                  frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

  logic [4*DIGITS-1:0] pending_val, shadow_val;
  logic [DIGITS-1:0]   pending_dp, shadow_dp;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          idx;

  logic                slot_end, frame_end;
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic                higher_zero, suppress, visible;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          dec_seg;

  always_comb begin
    slot_end    = enable && (cnt == CNT_LAST);
    frame_end   = slot_end && (idx == IDX_LAST);
    cur_nibble  = 4'h0;
    cur_dp      = 1'b0;
    higher_zero = 1'b1;
    an_next     = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_nibble = shadow_val[4*i +: 4];
        cur_dp     = shadow_dp[i];
      end
      if ((3'(i) >= idx) && (shadow_val[4*i +: 4] != 4'h0))
        higher_zero = 1'b0;
    end
    // Digit 0 is always shown so a zero value still reads "0".
    suppress = blank_lz && (idx != 3'd0) && higher_zero;
    visible  = enable && (int'(cnt) >= BLANK_CYCLES) && !suppress;
    for (int i = 0; i < DIGITS; i++) begin
      if (visible && (idx == 3'(i)))
        an_next[i] = 1'b0;
    end
  end

  hexdecoder u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // While disabled the shadow tracks pending continuously so re-enabling is instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_val <= '0;
      pending_dp  <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      cnt         <= '0;
      idx         <= '0;
    end else begin
      if (load) begin
        pending_val <= value;
        pending_dp  <= dp_in;
      end
      if (!enable || frame_end) begin
        shadow_val <= load ? value : pending_val;
        shadow_dp  <= load ? dp_in : pending_dp;
      end
      if (!enable) begin
        cnt <= '0;
        idx <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'b1000000;
      an_n       <= '1;
      dp_n       <= 1'b1;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      seg        <= dec_seg;
      an_n       <= an_next;
      dp_n       <= visible ? ~cur_dp : 1'b1;
      digit_idx  <= enable ? idx : 3'd0;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Randomized self-checking bench for sevenseg_scanner against a frame-position model
// (a single clock count within the frame, split into slot and phase arithmetically).

module tb_sevenseg_scanner;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FRAME = D * RD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, load, blank_lz;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [6:0]    seg;
  logic [3:0]    an_n;
  logic          dp_n;
  logic [2:0]    digit_idx;
  logic          frame_done;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [15:0] m_pend_v, m_shad_v;
  logic [3:0]  m_pend_dp, m_shad_dp;
  int          m_t;

  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_dp, exp_fd;
  logic [2:0]  exp_idx;

  sevenseg_scanner #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Common-anode active-low rendering of the usual hex glyphs.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  task automatic model_reset();
    m_pend_v = '0; m_shad_v = '0; m_pend_dp = '0; m_shad_dp = '0; m_t = 0;
  endtask

  // One clock: drive inputs at negedge, predict outputs of the coming edge, advance model.
  task automatic step(input logic en, input logic ld, input logic [15:0] val,
                      input logic [3:0] dp, input logic blz);
    int slot, phase;
    logic vis;
    @(negedge clk);
    enable = en; load = ld; value = val; dp_in = dp; blank_lz = blz;
    slot  = m_t / RD;
    phase = m_t % RD;
    vis = en && (phase >= BC) && !(blz && slot > 0 && (m_shad_v >> (4*slot)) == 16'h0);
    exp_seg = seg_of(4'((m_shad_v >> (4*slot)) & 16'hF));
    exp_an  = vis ? ~(4'b0001 << slot) : 4'hF;
    exp_dp  = vis ? ~m_shad_dp[slot] : 1'b1;
    exp_idx = en ? 3'(slot) : 3'd0;
    exp_fd  = en && (m_t == FRAME - 1);
    if (!en || m_t == FRAME - 1) begin
      m_shad_v  = ld ? val : m_pend_v;
      m_shad_dp = ld ? dp : m_pend_dp;
    end
    if (ld) begin
      m_pend_v = val; m_pend_dp = dp;
    end
    m_t = en ? (m_t + 1) % FRAME : 0;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 0; load = 0; value = '0; dp_in = '0; blank_lz = 0;
    model_reset();
    #12;
    checks++;
    if ({seg, an_n, dp_n, digit_idx, frame_done} !== {seg_of(4'h0), 4'hF, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_values: got seg=%h an_n=%b dp_n=%b idx=%0d fd=%b", seg, an_n, dp_n, digit_idx, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] want_an;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 16'h1234, 4'h0, 0);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL scan cycle %0d: got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b", cycle,
                 seg, an_n, dp_n, digit_idx, frame_done, exp_seg, exp_an, exp_dp, exp_idx, exp_fd);
      end
      if (k <= 5) begin
        want_an = (k >= 2 && k <= 4) ? 4'b1110 : 4'b1111;
        checks++;
        if (an_n !== want_an || (k >= 2 && k <= 4 && seg !== seg_of(4'h0))) begin
          failures++;
          $display("[TB] FAIL scan_edge%0d: got an_n=%b seg=%h want an_n=%b seg=%h", k, an_n, seg, want_an, seg_of(4'h0));
        end
      end
    end
  endtask

  task automatic test_tear_free();
    int last_fd = -1;
    while (m_t / RD != 2) begin
      step(1, 0, 16'h0, 4'h0, 0);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL tear_align cycle %0d: got %h/%b want %h/%b", cycle, seg, an_n, exp_seg, exp_an);
      end
    end
    for (int k = 0; k < 3 * FRAME; k++) begin
      step(1, k == 0, 16'h1234, 4'h0, 0);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL tear_free cycle %0d: got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b", cycle,
                 seg, an_n, dp_n, digit_idx, frame_done, exp_seg, exp_an, exp_dp, exp_idx, exp_fd);
      end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          checks++;
          if (cycle - last_fd != FRAME) begin
            failures++;
            $display("[TB] FAIL frame_period: got %0d clocks want %0d", cycle - last_fd, FRAME);
          end
        end
        last_fd = cycle;
      end
    end
    checks++;
    if (last_fd < 0) begin
      failures++;
      $display("[TB] FAIL frame_done_seen: got none want a pulse");
    end
  endtask

  task automatic test_boundary_load();
    int guard = 0;
    while (m_t != FRAME - 1 && guard < 2 * FRAME) begin
      step(1, 0, 16'h0, 4'h0, 0);
      guard++;
    end
    step(1, 1, 16'hABCD, 4'h0, 0);
    step(1, 0, 16'h0, 4'h0, 0);
    checks++;
    if (seg !== seg_of(4'hD) || seg !== exp_seg) begin
      failures++;
      $display("[TB] FAIL boundary_load: got seg=%h want %h", seg, seg_of(4'hD));
    end
    for (int k = 0; k < FRAME; k++) begin
      step(1, 0, 16'h0, 4'h0, 0);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL boundary_frame cycle %0d: got %h/%b want %h/%b", cycle, seg, an_n, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [2];
    int hi_lit, d1_lit;
    vals[0] = 16'h0070;
    vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      hi_lit = 0; d1_lit = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
        step(1, k == 0, vals[v], 4'h0, 1);
        checks++;
        if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
          failures++;
          $display("[TB] FAIL lz cycle %0d: got %h/%b want %h/%b", cycle, seg, an_n, exp_seg, exp_an);
        end
        if (k >= 2 * FRAME && an_n[3:2] !== 2'b11) hi_lit++;
        if (k >= 2 * FRAME && an_n[1] === 1'b0) d1_lit++;
      end
      checks++;
      if (hi_lit != 0 || d1_lit != (v == 0 ? RD - BC : 0)) begin
        failures++;
        $display("[TB] FAIL lz_digits v=%h: got hi=%0d d1=%0d want hi=0 d1=%0d", vals[v], hi_lit, d1_lit, v == 0 ? RD - BC : 0);
      end
    end
  endtask

  task automatic test_dp();
    for (int k = 0; k < 3 * FRAME; k++) begin
      step(1, k == 0, 16'h5A3C, 4'b0100, 0);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL dp cycle %0d: got dp_n=%b an_n=%b want dp_n=%b an_n=%b", cycle, dp_n, an_n, exp_dp, exp_an);
      end
      if (k >= 2 * FRAME) begin
        checks++;
        if (dp_n !== ~(an_n[2] === 1'b0)) begin
          failures++;
          $display("[TB] FAIL dp_digit2 cycle %0d: got dp_n=%b an_n=%b want dp_n low only with digit 2", cycle, dp_n, an_n);
        end
      end
    end
  endtask

  task automatic test_enable();
    while (m_t % RD != 2) step(1, 0, 16'h0, 4'h0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, k == 1, 16'h9876, 4'h0, 0);
      checks++;
      if (an_n !== 4'hF || digit_idx !== 3'd0 || {seg, dp_n, frame_done} !== {exp_seg, exp_dp, exp_fd}) begin
        failures++;
        $display("[TB] FAIL enable_off cycle %0d: got an_n=%b idx=%0d seg=%h want an_n=1111 idx=0 seg=%h", cycle, an_n, digit_idx, seg, exp_seg);
      end
    end
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step(1, 0, 16'h0, 4'h0, 0);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL reenable cycle %0d: got %h/%b/%0d want %h/%b/%0d", cycle, seg, an_n, digit_idx, exp_seg, exp_an, exp_idx);
      end
      if (k == BC + 1) begin
        checks++;
        if (an_n !== 4'b1110 || seg !== seg_of(4'h6)) begin
          failures++;
          $display("[TB] FAIL reenable_digit0: got an_n=%b seg=%h want 1110 %h", an_n, seg, seg_of(4'h6));
        end
      end
    end
  endtask

  task automatic test_random();
    logic en, ld, blz;
    logic [15:0] v;
    logic [3:0] dp;
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 15) != 0);
      ld  = ($urandom_range(0, 7) == 0);
      blz = ((k / 64) % 2 == 1);
      v   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      dp  = 4'($urandom);
      step(en, ld, v, dp, blz);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL random cycle %0d: got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b", cycle,
                 seg, an_n, dp_n, digit_idx, frame_done, exp_seg, exp_an, exp_dp, exp_idx, exp_fd);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    step(1, 1, 16'h4321, 4'hF, 0);
    while (exp_an == 4'hF && guard < 2 * FRAME) begin
      step(1, 0, 16'h0, 4'h0, 0);
      guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({seg, an_n, dp_n, digit_idx, frame_done} !== {seg_of(4'h0), 4'hF, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL async_reset: got seg=%h an_n=%b dp_n=%b idx=%0d", seg, an_n, dp_n, digit_idx);
    end
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < FRAME + 2; k++) begin
      step(1, 0, 16'h0, 4'h0, 0);
      checks++;
      if ({seg, an_n, dp_n, digit_idx, frame_done} !== {exp_seg, exp_an, exp_dp, exp_idx, exp_fd}) begin
        failures++;
        $display("[TB] FAIL post_reset cycle %0d: got %h/%b want %h/%b", cycle, seg, an_n, exp_seg, exp_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_boundary_load();
    test_lz();
    test_dp();
    test_enable();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
